// File: rtl/seed_random_1_card_draw_if.sv
// seed_random_1_card_draw_if: control-path request/seed inputs and the card valid/ack handshake.
interface seed_random_1_card_draw_if;
    logic        state_i;
    logic        seed_load_i;
    logic [15:0] seed_i;
    logic        card_ack_i;
    logic [3:0]  card_rank_o;
    logic [4:0]  card_points_o;
    logic        card_valid_o;
    logic        busy_o;

    modport master (
        output state_i, seed_load_i, seed_i, card_ack_i,
        input  card_rank_o, card_points_o, card_valid_o, busy_o
    );

    modport slave (
        input  state_i, seed_load_i, seed_i, card_ack_i,
        output card_rank_o, card_points_o, card_valid_o, busy_o
    );
endinterface

// File: rtl/seed_random_1_card_draw.sv
// seed_random_1_card_draw: draws one card per SEND edge from a 16-bit LFSR via rejection sampling,
// converts it to blackjack points and holds it under valid/ack.
module seed_random_1_card_draw #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned MAX_TRIES = 8
) (
    input logic clk_dp_i,
    input logic rst_dp_i,
    seed_random_1_card_draw_if.slave cd
);
    typedef enum logic [1:0] {IDLE, DRAW, HOLD} fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        state_q;
    logic [3:0]  tries_q, tries_d, tries_inc;
    logic [3:0]  rank_q, rank_d;
    logic [4:0]  points_q, points_d;
    logic [3:0]  s;
    logic        req, load, accept;

    assign req       = cd.state_i & ~state_q;
    assign load      = cd.seed_load_i & (fsm_q == IDLE);
    assign s         = lfsr_q[3:0];
    assign accept    = s <= 4'd12;
    assign tries_inc = tries_q + 4'd1;
    // a zero load is replaced by SEED so the LFSR can never lock up
    assign lfsr_d    = load ? ((cd.seed_i == 16'h0000) ? SEED : cd.seed_i)
                            : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign points_d  = (rank_d == 4'd1) ? 5'd11 : (rank_d >= 4'd11) ? 5'd10 : {1'b0, rank_d};

    always_comb begin
        fsm_d   = fsm_q;
        tries_d = tries_q;
        rank_d  = rank_q;
        case (fsm_q)
            IDLE: begin
                fsm_d   = req ? DRAW : IDLE;
                tries_d = req ? 4'd0 : tries_q;
            end
            DRAW: begin
                tries_d = accept ? tries_q : tries_inc;
                if (accept || tries_inc == 4'(MAX_TRIES)) begin
                    fsm_d  = HOLD;
                    rank_d = accept ? s + 4'd1 : s - 4'd12;
                end
            end
            HOLD:    fsm_d = cd.card_ack_i ? IDLE : HOLD;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_dp_i or posedge rst_dp_i) begin
        if (rst_dp_i) begin
            fsm_q    <= IDLE;
            lfsr_q   <= SEED;
            state_q  <= 1'b0;
            tries_q  <= 4'd0;
            rank_q   <= 4'd0;
            points_q <= 5'd0;
        end else begin
            fsm_q    <= fsm_d;
            lfsr_q   <= lfsr_d;
            state_q  <= cd.state_i;
            tries_q  <= tries_d;
            rank_q   <= rank_d;
            points_q <= points_d;
        end
    end

    assign cd.card_rank_o   = rank_q;
    assign cd.card_points_o = points_q;
    assign cd.card_valid_o  = fsm_q == HOLD;
    assign cd.busy_o        = fsm_q != IDLE;
endmodule

// File: tb/tb_seed_random_1_card_draw.sv
// tb_seed_random_1_card_draw: directed vectors on two instances (MAX_TRIES 8 and 2) sharing one stimulus.
module tb_seed_random_1_card_draw;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    seed_random_1_card_draw_if cd();
    seed_random_1_card_draw_if cd2();

    seed_random_1_card_draw #(.SEED(16'hACE1), .MAX_TRIES(8)) dut (
        .clk_dp_i(clk), .rst_dp_i(rst), .cd(cd.slave));
    seed_random_1_card_draw #(.SEED(16'hACE1), .MAX_TRIES(2)) dut2 (
        .clk_dp_i(clk), .rst_dp_i(rst), .cd(cd2.slave));

    assign cd2.state_i     = cd.state_i;
    assign cd2.seed_load_i = cd.seed_load_i;
    assign cd2.seed_i      = cd.seed_i;
    assign cd2.card_ack_i  = cd.card_ack_i;

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] seed;
        int r8, p8, d8, r2, p2, d2;
    } vec_t;
    vec_t v[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic request(input logic [15:0] seed, input bit ld);
        cd.state_i     = 1'b1;
        cd.seed_load_i = ld;
        cd.seed_i      = seed;
        tick();
        cd.seed_load_i = 1'b0;
    endtask

    task automatic wait_cards(output int d1, output int d2);
        d1 = -1;
        d2 = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (d1 < 0 && cd.card_valid_o) d1 = k;
            if (d2 < 0 && cd2.card_valid_o) d2 = k;
            if (d1 >= 0 && d2 >= 0) break;
        end
    endtask

    task automatic ack;
        cd.card_ack_i = 1'b1;
        tick();
        cd.card_ack_i = 1'b0;
    endtask

    initial begin
        int d1, d2, n, r, p;
        cd.state_i     = 1'b0;
        cd.seed_load_i = 1'b0;
        cd.seed_i      = 16'h0000;
        cd.card_ack_i  = 1'b0;

        v[0] = '{16'h0004,  5,  5, 1,  5,  5, 1};
        v[1] = '{16'h0010,  1, 11, 1,  1, 11, 1};
        v[2] = '{16'h000A, 11, 10, 1, 11, 10, 1};
        v[3] = '{16'h000F, 13, 10, 3,  2,  2, 2};
        v[4] = '{16'h0000,  2,  2, 1,  2,  2, 1};
        v[5] = '{16'h000D, 11, 10, 2, 11, 10, 2};
        v[6] = '{16'h000C, 13, 10, 1, 13, 10, 1};

        tick();
        tick();
        check("reset_valid", cd.card_valid_o, 0);
        check("reset_busy", cd.busy_o, 0);
        check("reset_rank", cd.card_rank_o, 0);
        check("reset_points", cd.card_points_o, 0);
        rst = 1'b0;
        tick();

        foreach (v[i]) begin
            cd.state_i = 1'b0;
            tick();
            request(v[i].seed, 1'b1);
            cd.state_i = 1'b0;
            wait_cards(d1, d2);
            check($sformatf("v%0d_draws8", i), d1, v[i].d8);
            check($sformatf("v%0d_draws2", i), d2, v[i].d2);
            check($sformatf("v%0d_rank8", i), cd.card_rank_o, v[i].r8);
            check($sformatf("v%0d_points8", i), cd.card_points_o, v[i].p8);
            check($sformatf("v%0d_rank2", i), cd2.card_rank_o, v[i].r2);
            check($sformatf("v%0d_points2", i), cd2.card_points_o, v[i].p2);
            check($sformatf("v%0d_busy", i), cd.busy_o, 1);
            ack();
            check($sformatf("v%0d_valid_after_ack", i), cd.card_valid_o, 0);
            check($sformatf("v%0d_busy_after_ack", i), cd.busy_o, 0);
            check($sformatf("v%0d_rank_kept", i), cd.card_rank_o, v[i].r8);
        end

        // held SEND level: exactly one card over 25 cycles, acked as soon as it appears
        cd.state_i = 1'b0;
        tick();
        request(16'h0010, 1'b1);
        n = 0;
        for (int k = 0; k < 25; k++) begin
            cd.card_ack_i = cd.card_valid_o;
            if (cd.card_valid_o) n++;
            tick();
        end
        cd.card_ack_i = 1'b0;
        check("held_send_cards", n, 1);

        // second edge during HOLD is dropped; delayed ack keeps outputs stable
        cd.state_i = 1'b0;
        tick();
        request(16'h0004, 1'b1);
        cd.state_i = 1'b0;
        wait_cards(d1, d2);
        cd.state_i = 1'b1;
        tick();
        cd.state_i = 1'b0;
        n = 0;
        r = cd.card_rank_o;
        p = cd.card_points_o;
        for (int k = 0; k < 5; k++) begin
            if (!cd.card_valid_o || cd.card_rank_o != 4'd5 || cd.card_points_o != 5'd5) n++;
            tick();
        end
        check("hold_unstable_cycles", n, 0);
        check("hold_rank", r, 5);
        check("hold_points", p, 5);
        ack();
        check("delayed_ack_valid_drop", cd.card_valid_o, 0);
        tick();
        tick();
        check("dropped_edge_not_queued", cd.busy_o, 0);

        // request in the ack cycle is not seen
        request(16'h0004, 1'b1);
        cd.state_i = 1'b0;
        wait_cards(d1, d2);
        cd.card_ack_i = 1'b1;
        cd.state_i = 1'b1;
        tick();
        cd.card_ack_i = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (cd.busy_o) n++;
            tick();
        end
        check("ack_cycle_request_busy", n, 0);
        check("ack_cycle_request_valid", cd.card_valid_o, 0);

        // asynchronous reset mid-HOLD
        cd.state_i = 1'b0;
        tick();
        request(16'h000A, 1'b1);
        cd.state_i = 1'b0;
        wait_cards(d1, d2);
        check("pre_reset_valid", cd.card_valid_o, 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", cd.card_valid_o, 0);
        check("async_reset_busy", cd.busy_o, 0);
        check("async_reset_rank", cd.card_rank_o, 0);
        check("async_reset_points", cd.card_points_o, 0);
        check("async_reset_valid2", cd2.card_valid_o, 0);
        @(negedge clk);
        // LFSR restarts at ACE1; the first DRAW sees the advanced value 59C3 -> sample 3 -> rank 4
        rst = 1'b0;
        cd.state_i = 1'b1;
        tick();
        cd.state_i = 1'b0;
        wait_cards(d1, d2);
        check("post_reset_draws", d1, 1);
        check("post_reset_rank", cd.card_rank_o, 4);
        check("post_reset_points", cd.card_points_o, 4);
        ack();
        check("post_reset_valid_drop", cd.card_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seed_random_1_card_draw.md
Name: seed_random_1_card_draw

Overview:
- Datapath stage downstream of the seed-random control path. It consumes that block's 1-bit IDLE/SEND state and produces one random card per request for the blackjack engine.
- A 16-bit LFSR supplies candidate values. Rejection sampling maps them to ranks 1..13, and each rank is converted to blackjack points.
- The card is held under a valid/ack handshake until the game logic takes it.

Parameters:
- SEED, 16'hACE1, LFSR value used at reset and whenever a zero seed is loaded.
- MAX_TRIES, 8, rejected samples allowed before the deterministic fallback (range 1..15).

Ports:
- clk_dp_i  input  1  clock; all logic on the rising edge.
- rst_dp_i  input  1  asynchronous, active-high reset.
- state_i  input  1  control-path state; 0 = IDLE, 1 = SEND.
- seed_load_i  input  1  load seed_i into the LFSR; honoured only in IDLE.
- seed_i  input  16  seed value.
- card_ack_i  input  1  consumer accepts the card.
- card_rank_o  output  4  card rank: 1 = A, 2..10, 11 = J, 12 = Q, 13 = K.
- card_points_o  output  5  blackjack points.
- card_valid_o  output  1  card outputs valid.
- busy_o  output  1  high in DRAW and HOLD.

Behaviour:
- Reset (asynchronous, while rst_dp_i = 1):
  - lfsr = SEED, FSM = IDLE, state_q = 0, tries = 0.
  - card_rank_o = 0, card_points_o = 0, card_valid_o = 0, busy_o = 0.
  - Reset asserted mid-draw or mid-hold aborts immediately; no card is delivered.
- LFSR (Fibonacci):
  - Update: next = {lfsr[14:0], fb}, with fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - Advances every cycle except a cycle in which a load is honoured.
  - A load of seed_i = 0 loads SEED instead, so the LFSR never holds zero.
- Request detect:
  - state_q registers state_i every cycle.
  - A request is state_i = 1 and state_q = 0 (rising edge). A held SEND level produces exactly one card.
- FSM state IDLE:
  - On a request, go to DRAW next cycle and set tries = 0.
  - seed_load_i in the same cycle as a request is honoured. The first DRAW cycle then samples seed_i (or SEED if seed_i = 0).
- FSM state DRAW: each cycle, sample s = lfsr[3:0].
  - If s <= 12: register rank = s+1, go to HOLD.
  - Else: tries = tries+1. If the new tries value equals MAX_TRIES, register fallback rank = s-12 (13→1, 14→2, 15→3) and go to HOLD. Otherwise stay in DRAW.
- FSM state HOLD:
  - card_valid_o = 1; rank and points are stable.
  - When card_ack_i = 1, go to IDLE; card_valid_o = 0 the next cycle. Outputs keep their last values.
  - card_ack_i outside HOLD is ignored.
- Points mapping: rank 1 → 11; ranks 2..10 → rank; ranks 11..13 → 10. Points are registered together with rank.
- Latency: request at cycle N → first DRAW cycle N+1 → card_valid_o at N+2 at best, and N+1+MAX_TRIES at worst.
- Simultaneous and late events:
  - Requests during DRAW or HOLD are dropped, not queued.
  - seed_load_i outside IDLE is ignored.
  - A request in the same cycle that HOLD is acked is not seen (the FSM is not in IDLE). state_i must fall and rise again.
- busy_o = 1 exactly in DRAW and HOLD.

Test Plan:
- Reset: assert rst_dp_i asynchronously mid-HOLD → all outputs 0 immediately; after release, FSM is in IDLE and lfsr = 16'hACE1.
- Direct accept: seed_load_i = 1 with seed_i = 16'h0004 and a state_i rising edge in the same cycle → two cycles later card_rank_o = 5, card_points_o = 5, valid held until ack; seed 16'h0010 → rank 1, points 11; seed 16'h000A → rank 11, points 10.
- Rejection: seed 16'h000F, MAX_TRIES = 8 → samples F, E, C; valid appears after 3 DRAW cycles with rank 13, points 10.
- Fallback: seed 16'h000F, MAX_TRIES = 2 → samples F, E; rank 2, points 2 after 2 DRAW cycles.
- Zero seed: load 16'h0000 with a request → samples 1 from 16'hACE1; rank 2, points 2.
- Handshake and edges: hold state_i = 1 for 20 cycles → exactly one card. A second edge during HOLD is dropped. Delay ack by 5 cycles → outputs stable throughout; valid drops the cycle after ack.
